// File: rtl/vga_pkg.sv
// vga_pkg: tile geometry shared by the VGA tile path and the loader FSM state encoding.
//   COLS, ROWS : tile columns / rows per frame
//   N          : tiles per frame (COLS*ROWS)
//   AW         : tile RAM address width
//   state_t    : tile_loader FSM states
package vga_pkg;

    localparam int COLS = 20;
    localparam int ROWS = 15;
    localparam int N    = COLS * ROWS;
    localparam int AW   = 9;

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        WRITE
    } state_t;

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with registered occupancy and fall-through read data.
//   clk, reset_n : clock, asynchronous active-low reset (empties the FIFO)
//   push, wdata  : write strobe and data (caller guarantees !full)
//   pop, rdata   : read strobe (caller guarantees !empty); rdata shows the head entry
//   full, empty  : flags decoded from the registered count only
module sync_fifo #(
    parameter int W     = 9,
    parameter int DEPTH = 16
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         push,
    input  logic [W-1:0] wdata,
    input  logic         pop,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wp_q, rp_q;
    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (push) mem_q[wp_q] <= wdata;
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
        end else begin
            wp_q  <= wp_q + PW'(push);
            rp_q  <= rp_q + PW'(pop);
            cnt_q <= cnt_q + CW'(push) - CW'(pop);
        end
    end

    assign rdata = mem_q[rp_q];
    assign full  = cnt_q == CW'(DEPTH);
    assign empty = cnt_q == '0;

endmodule

// File: rtl/tile_loader.sv
// tile_loader: buffers incoming tile bytes and writes them into the tile RAM only during vblank.
//   clk, reset_n               : 25 MHz pixel clock, asynchronous active-low reset
//   in_data, in_sof, in_valid  : upstream byte stream; sof marks the byte for tile 0
//   in_ready                   : FIFO not full (registered, no path from in_valid)
//   vblank                     : RAM writes allowed while high
//   we, addr, wdata            : registered tile RAM write port
//   frame_done                 : pulses with the write to the last tile
//   busy                       : FIFO non-empty or a write in flight
module tile_loader #(
    parameter int COLS  = vga_pkg::COLS,
    parameter int ROWS  = vga_pkg::ROWS,
    parameter int AW    = vga_pkg::AW,
    parameter int DEPTH = 16
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [7:0]    in_data,
    input  logic          in_sof,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          vblank,
    output logic          we,
    output logic [AW-1:0] addr,
    output logic [7:0]    wdata,
    output logic          frame_done,
    output logic          busy
);

    import vga_pkg::*;

    localparam logic [AW-1:0] LAST = AW'(COLS * ROWS - 1);

    state_t        state_q, state_d;
    logic          full, empty, push, pop;
    logic [8:0]    head;
    logic          we_q, fd_q, first_q;
    logic [AW-1:0] addr_q, addr_d;
    logic [7:0]    wdata_q;

    assign push = in_valid & ~full;
    // Pop is gated by vblank too, so a vblank drop stops popping on the very next edge.
    assign pop  = (state_q == WRITE) & ~empty & vblank;

    sync_fifo #(.W(9), .DEPTH(DEPTH)) u_fifo (
        .clk    (clk),
        .reset_n(reset_n),
        .push   (push),
        .wdata  ({in_sof, in_data}),
        .pop    (pop),
        .rdata  (head),
        .full   (full),
        .empty  (empty)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // HOLD is never left towards IDLE since nothing pops there, so one rule covers every state.
    always_comb begin
        state_d = empty ? IDLE : (vblank ? WRITE : HOLD);
    end

    // The first write after reset lands at 0 even without sof, so a reset mid-frame resynchronises.
    always_comb begin
        addr_d = (head[8] | first_q | addr_q == LAST) ? '0 : addr_q + AW'(1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            we_q    <= 1'b0;
            fd_q    <= 1'b0;
            first_q <= 1'b1;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            we_q <= pop;
            fd_q <= pop & (addr_d == LAST);
            if (pop) begin
                first_q <= 1'b0;
                addr_q  <= addr_d;
                wdata_q <= head[7:0];
            end
        end
    end

    assign in_ready   = ~full;
    assign we         = we_q;
    assign addr       = addr_q;
    assign wdata      = wdata_q;
    assign frame_done = fd_q;
    assign busy       = ~empty | we_q;

endmodule

// File: doc/tile_loader.md
TILE_LOADER -- requirements
Module: tile_loader

Interface
REQ-001 Parameter COLS, default 20, tile columns per frame.
REQ-002 Parameter ROWS, default 15, tile rows per frame; tiles per frame N = COLS*ROWS = 300.
REQ-003 Parameter AW, default 9, tile RAM address width.
REQ-004 Parameter DEPTH, default 16, input FIFO entries (power of two).
REQ-005 clk  input  1  single clock, the 25 MHz pixel clock shared with the tile RAM and VGA timing.
REQ-006 reset_n  input  1  asynchronous, active-low reset.
REQ-007 in_data  input  8  tile byte {2'b0, R[1:0], G[1:0], B[1:0]}.
REQ-008 in_sof  input  1  start-of-frame marker, qualified by in_valid; that byte targets tile 0.
REQ-009 in_valid  input  1  upstream byte valid.
REQ-010 in_ready  output  1  FIFO can accept; a transfer occurs when in_valid & in_ready.
REQ-011 vblank  input  1  high while the VGA timing is outside the visible area; RAM writes are permitted only then.
REQ-012 we  output  1  tile RAM write enable.
REQ-013 addr  output  AW  tile RAM write address.
REQ-014 wdata  output  8  tile RAM write data; top level drives the RAM's bidirectional data bus with it while we=1.
REQ-015 frame_done  output  1  one-cycle pulse coincident with the write to address N-1.
REQ-016 busy  output  1  high when the FIFO is non-empty or we=1.

Function
REQ-017 The FIFO shall store {in_sof, in_data} (9 bits) and accept on in_valid & in_ready.
REQ-018 in_ready shall equal !full, derived from registered FIFO count only (no combinational path from in_valid).
REQ-019 The FSM shall have three states: IDLE (FIFO empty), HOLD (FIFO non-empty, vblank=0), WRITE (pop and write each cycle).
REQ-020 Transitions: IDLE->WRITE when FIFO non-empty & vblank; IDLE->HOLD when non-empty & !vblank; HOLD->WRITE on vblank; WRITE->HOLD on !vblank with data remaining; WRITE->IDLE when the FIFO empties.
REQ-021 Each pop shall produce we=1 with registered addr/wdata on the following cycle; at most one write per cycle.
REQ-022 Minimum latency: a byte accepted at edge k, with vblank high and FIFO previously empty, shall appear on we/addr/wdata after edge k+2.
REQ-023 A popped entry with sof=1 shall be written at address 0; otherwise at previous write address + 1.
REQ-024 After a write to N-1 the next non-sof address shall wrap to 0; addresses N..2^AW-1 shall never be written.
REQ-025 frame_done shall pulse only on a write to address N-1.
REQ-026 vblank falling during WRITE shall complete the write already popped; no further pop until vblank rises.
REQ-027 Simultaneous push and pop shall leave the count unchanged; push while full shall be impossible (in_ready=0).
REQ-028 we shall be 0 in every cycle without a pop on the previous edge.

Reset
REQ-029 On reset_n=0, asynchronously: FIFO empty, in_ready=1, state IDLE, we=0, addr=0, wdata=0, frame_done=0, busy=0.
REQ-030 Reset mid-frame shall discard FIFO contents; the next write after release goes to address 0.

Structure
REQ-031 Tile geometry constants (COLS, ROWS, N, AW) and the FSM state enum shall reside in a shared package, vga_pkg.
REQ-032 The FIFO shall be one sub-module, sync_fifo, parameterised by width and depth.

Verification
REQ-033 Reset, vblank=1, stream 300 bytes 0x00..0x2B repeating with sof on the first -> writes to addr 0..299 in order, frame_done exactly once at addr 299.
REQ-034 vblank=0, push 16 bytes -> in_ready=0 after the 16th, we stays 0; raise vblank -> 16 consecutive writes, in_ready returns to 1.
REQ-035 vblank=1, single byte 0x15 at edge k with empty FIFO -> we=1, addr=0, wdata=0x15 after edge k+2.
REQ-036 Write 5 bytes, then a byte with sof=1 value 0x3F -> 0x3F written at addr 0, next byte at addr 1.
REQ-037 Drop vblank after 3 writes of a 10-byte burst -> exactly 3 writes, busy=1, remaining 7 written after vblank rises.
REQ-038 Assert reset_n=0 at tile 150 with 8 bytes queued -> we=0 immediately, in_ready=1; next byte written to addr 0.
